param_shift_seq: RTL
====================

PARAM_SHIFT_SEQ -- requirements
Module: param_shift_seq

Interface
REQ-001 Parameter WIDTH, default 8: data register width in bits, legal range 2..64.
REQ-002 Parameter CNT_W, default 4: width of the shift-amount field, giving a maximum burst of 2^CNT_W-1 shifts.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port load, input, 1 bit: parallel-load request.
REQ-006 Port data_in, input, WIDTH bits: parallel-load value.
REQ-007 Port start, input, 1 bit: shift-burst request.
REQ-008 Port mode, input, 2 bits: 00 shift left logical, 01 shift right logical, 10 rotate left, 11 rotate right.
REQ-009 Port amount, input, CNT_W bits: number of single-bit shifts in the burst.
REQ-010 Port ser_in, input, 1 bit: fill bit for logical shifts, sampled on every shift edge.
REQ-011 Port data_out, output, WIDTH bits: registered contents.
REQ-012 Port ser_out, output, 1 bit: registered copy of the bit that left data_out on the most recent shift.
REQ-013 Port busy, output, 1 bit: high while a burst is in progress.
REQ-014 Port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-015 The block SHALL implement a two-state machine: IDLE and SHIFT.
REQ-016 In IDLE with load=1, data_out SHALL equal data_in after the next edge; state stays IDLE and done stays 0.
REQ-017 In IDLE with start=1 and load=0, on sampling edge E0 the block SHALL latch mode and amount, enter SHIFT and assert busy.
REQ-018 In SHIFT, exactly one single-bit shift SHALL occur on each of edges E1..EN, where N is the latched amount, using the latched mode; mid-burst changes to mode or amount SHALL have no effect.
REQ-019 Left logical shift: data_out <= {data_out[WIDTH-2:0], ser_in}; ser_out <= old MSB.
REQ-020 Right logical shift: data_out <= {ser_in, data_out[WIDTH-1:1]}; ser_out <= old LSB.
REQ-021 Rotate left: old MSB is written into the LSB and ser_out <= old MSB; rotate right: old LSB is written into the MSB and ser_out <= old LSB; ser_in is ignored for rotates.
REQ-022 After edge EN, the block SHALL return to IDLE with busy=0 and done=1 for exactly one cycle.
REQ-023 start with amount=0 SHALL leave data_out and ser_out unchanged, keep busy at 0, and assert done for one cycle after E0.
REQ-024 When load and start are both 1 in IDLE, load SHALL take priority and start is dropped.
REQ-025 While busy=1, load and start SHALL be ignored.
REQ-026 start may be asserted in the done cycle; the new burst is accepted as in REQ-017.
REQ-027 ser_out SHALL hold its value whenever no shift occurs.

Reset
REQ-028 With rst=1 at an edge, the block SHALL set data_out=0, ser_out=0, busy=0, done=0 and state IDLE; rst overrides load and start.
REQ-029 Reset during a burst SHALL abort it with no done pulse; the next edge with rst=0 behaves as IDLE.

Configuration
REQ-030 Macro SHIFT_PARITY_EN: when defined, the block SHALL add a 1-bit output port parity, equal to the XOR reduction of data_out and updated combinationally from the register.
REQ-031 When SHIFT_PARITY_EN is undefined, the parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset check: assert rst for 2 cycles -> data_out=0x00, ser_out=0, busy=0, done=0.
REQ-033 Load and left shift: load 0xA5, then start with mode=00, amount=3, ser_in=1 -> busy high for 3 cycles, data_out=0x2F, ser_out=1, then done high for one cycle.
REQ-034 Rotate right: load 0x81, then start with mode=11, amount=4 -> data_out=0x18, ser_out=0, done high for one cycle.
REQ-035 Zero amount and collision: start with amount=0 -> done pulses, data_out unchanged; load=1 and start=1 together with data_in=0x3C -> data_out=0x3C, busy stays 0.
REQ-036 Abort: start with mode=01, amount=7, on 0xFF; assert rst at the third shift edge -> data_out=0x00, no done pulse, busy=0.
REQ-037 Parity, with SHIFT_PARITY_EN defined: load 0x07 -> parity=1; load 0x03 -> parity=0.

Source files
------------

// File: rtl/param_shift_seq.sv
// Parameterised shift/rotate burst sequencer with parallel load and a done pulse.
// Optional parity output when SHIFT_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for load or start; done pulses here for one cycle after a burst
// SHIFT | one single-bit shift per edge until the latched amount is exhausted
module param_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_shift_data;
  logic             w_shift_bit;
  logic             w_last;

  // Single-bit step for the latched mode; only consumed while in SHIFT.
  always_comb begin
    w_shift_data = r_data;
    w_shift_bit  = r_ser;
    unique case (r_mode)
      MODE_SLL: begin
        w_shift_data = {r_data[WIDTH-2:0], ser_in};
        w_shift_bit  = r_data[WIDTH-1];
      end
      MODE_SRL: begin
        w_shift_data = {ser_in, r_data[WIDTH-1:1]};
        w_shift_bit  = r_data[0];
      end
      MODE_ROL: begin
        w_shift_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_shift_bit  = r_data[WIDTH-1];
      end
      MODE_ROR: begin
        w_shift_data = {r_data[0], r_data[WIDTH-1:1]};
        w_shift_bit  = r_data[0];
      end
      default: begin
        w_shift_data = r_data;
        w_shift_bit  = r_ser;
      end
    endcase
  end

  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= MODE_SLL;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (load) begin
            r_data <= data_in;
          end else if (start) begin
            r_mode <= mode;
            r_cnt  <= amount;
            // A zero-length burst completes immediately without visiting SHIFT.
            if (amount == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_data <= w_shift_data;
          r_ser  <= w_shift_bit;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign ser_out  = r_ser;
  assign busy     = r_busy;
  assign done     = r_done;

`ifdef SHIFT_PARITY_EN
  assign parity = ^r_data;
`endif

endmodule
